// File: rtl/vram_write_sched.sv
// vram_write_sched
// Buffers bus writes aimed at VRAM and commits them to the VRAM address
// decoder only during vertical blanking, one entry per clock, in the
// order they were accepted.
//
// Build option: define WQ_VBLANK_BYPASS_EN to let a write that arrives
// during vblank with an empty queue skip the queue and commit on the
// next clock. Without it every write goes through the queue.

module vram_write_sched #(
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chip_select,
    input  logic                    write,
    input  logic [11:0]             address,
    input  logic [31:0]             writedata,
    output logic                    waitrequest,
    input  logic                    vblank,
    output logic                    mem_write,
    output logic [11:0]             mem_addr,
    output logic [31:0]             mem_writedata,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 12 + 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [EW-1:0]   r_queue [DEPTH];

    logic            r_mem_write;
    logic [11:0]     r_mem_addr;
    logic [31:0]     r_mem_writedata;

    logic            w_full;
    logic            w_empty;
    logic            w_wr_req;
    logic            w_accept;
    logic            w_bypass;
    logic            w_push;
    logic            w_pop;
    logic [LW-1:0]   w_level_next;
    logic [EW-1:0]   w_head;

    // Occupancy flags; level counts from 0 to DEPTH inclusive.
    assign w_full   = (r_level == LW'(DEPTH));
    assign w_empty  = (r_level == '0);

    // A bus write is only refused when the queue is already full at the
    // start of the cycle, even if a pop frees a slot on the same edge.
    assign w_wr_req    = chip_select & write;
    assign waitrequest = w_wr_req & w_full;
    assign w_accept    = w_wr_req & ~w_full;

    // Pops happen whenever the scheduler is armed (WAIT_VB or DRAIN) and
    // vblank is high; popping on the WAIT_VB->DRAIN edge uses every
    // blanking cycle. IDLE never pops, so a write landing in an empty
    // queue needs one cycle for the FSM to notice it.
    assign w_pop = vblank & ~w_empty & (r_state != ST_IDLE);

`ifdef WQ_VBLANK_BYPASS_EN
    // Empty queue during blanking: commit the bus write directly.
    assign w_bypass = w_accept & vblank & w_empty & ~w_pop;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_accept & ~w_bypass;
    assign w_head = r_queue[r_rd_ptr];

    // Next occupancy; a simultaneous push and pop leave it unchanged.
    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    // Queue storage: written on push, read at the head pointer; contents
    // are don't-care after reset because the pointers and level clear.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_queue[r_wr_ptr] <= {address, writedata};
        end
    end

    // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_next;
        end
    end

    // Scheduler FSM with registered busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= vblank ? ST_DRAIN : ST_WAIT_VB;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT_VB: begin
                    if (vblank) begin
                        if (w_level_next == '0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_DRAIN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_level_next == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!vblank) begin
                        r_state <= ST_WAIT_VB;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Commit port: one-cycle strobe per pop or bypass; address and data
    // hold their last committed values between strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_write     <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_writedata <= '0;
        end else begin
            r_mem_write <= w_pop | w_bypass;
            if (w_pop) begin
                r_mem_addr      <= w_head[EW-1:32];
                r_mem_writedata <= w_head[31:0];
            end else if (w_bypass) begin
                r_mem_addr      <= address;
                r_mem_writedata <= writedata;
            end
        end
    end

    assign mem_write     = r_mem_write;
    assign mem_addr      = r_mem_addr;
    assign mem_writedata = r_mem_writedata;
    assign level         = r_level;
    assign busy          = r_busy;

endmodule
